// File: rtl/read_busy_ctrl.sv
// Round-robin read/busy sequencer for a shared read port: one grant at a time, bursts capped at MAX_BURST,
// busy held two cycles past read. Define READ_BUSY_CTRL_B2B_EN to allow back-to-back grants from TAIL2.
module read_busy_ctrl #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    read,
    output logic                    busy,
    output logic                    trunc
);

    localparam int IDW = $clog2(NREQ);
    localparam logic [7:0] MAXB = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        TAIL1 = 2'd2,
        TAIL2 = 2'd3
    } state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [7:0]      r_cnt;
    logic [NREQ-1:0] r_gnt;
    logic [IDW-1:0]  r_gnt_id;
    logic            r_read;
    logic            r_busy;
    logic            r_trunc;

    logic            w_found;
    logic [IDW-1:0]  w_winner;
    logic [IDW-1:0]  w_idx;
    logic [IDW-1:0]  w_next_ptr;
    logic [NREQ-1:0] w_onehot;
    logic            w_hold;
    logic            w_arb;

`ifdef READ_BUSY_CTRL_B2B_EN
    assign w_arb = (r_state == IDLE) || (r_state == TAIL2);
`else
    assign w_arb = (r_state == IDLE);
`endif

    assign w_hold = req[r_gnt_id];

    // Round-robin search: first requester at or after r_ptr, wrapping modulo NREQ
    always_comb begin
        w_found  = 1'b0;
        w_winner = {IDW{1'b0}};
        w_idx    = {IDW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            w_idx = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end else begin
                w_found  = w_found;
            end
        end
    end

    // Pointer advance and one-hot grant vector for the current winner
    always_comb begin
        w_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
        if (w_winner == IDW'(NREQ - 1)) begin
            w_next_ptr = {IDW{1'b0}};
        end else begin
            w_next_ptr = w_winner + IDW'(1);
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= {IDW{1'b0}};
            r_cnt    <= 8'd0;
            r_gnt    <= {NREQ{1'b0}};
            r_gnt_id <= {IDW{1'b0}};
            r_read   <= 1'b0;
            r_busy   <= 1'b0;
            r_trunc  <= 1'b0;
        end else begin
            r_trunc <= 1'b0;
            case (r_state)
                READ: begin
                    if (w_hold && (r_cnt < MAXB)) begin
                        r_cnt <= r_cnt + 8'd1;
                    end else begin
                        // still requesting here means the burst hit the cap
                        r_state <= TAIL1;
                        r_read  <= 1'b0;
                        r_gnt   <= {NREQ{1'b0}};
                        r_trunc <= w_hold;
                    end
                end
                TAIL1: begin
                    r_state <= TAIL2;
                end
                IDLE, TAIL2: begin
                    if (w_arb && w_found) begin
                        r_state  <= READ;
                        r_read   <= 1'b1;
                        r_busy   <= 1'b1;
                        r_gnt    <= w_onehot;
                        r_gnt_id <= w_winner;
                        r_ptr    <= w_next_ptr;
                        r_cnt    <= 8'd1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_read  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_gnt   <= {NREQ{1'b0}};
                end
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign gnt_id = r_gnt_id;
    assign read   = r_read;
    assign busy   = r_busy;
    assign trunc  = r_trunc;

endmodule

// File: tb/tb_read_busy_ctrl.sv
// Directed bench for read_busy_ctrl (NREQ=4, MAX_BURST=8); honours READ_BUSY_CTRL_B2B_EN for gap expectations.
module tb_read_busy_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       read;
    logic       busy;
    logic       trunc;

    int checks   = 0;
    int failures = 0;

    read_busy_ctrl #(.NREQ(4), .MAX_BURST(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .read   (read),
        .busy   (busy),
        .trunc  (trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock, sample 1 time unit after the edge, check structural invariants
    task automatic step();
        @(posedge clk);
        #1;
        chk("read_eq_or_gnt", 32'(read), 32'(|gnt));
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic chk_state(input string tag, input logic r, input logic b, input logic [3:0] g, input logic t);
        chk({tag, "_read"}, 32'(read), 32'(r));
        chk({tag, "_busy"}, 32'(busy), 32'(b));
        chk({tag, "_gnt"}, 32'(gnt), 32'(g));
        chk({tag, "_trunc"}, 32'(trunc), 32'(t));
    endtask

    int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;

        // reset held 3 cycles with all requests high
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state("reset", 1'b0, 1'b0, 4'b0000, 1'b0);
        end
        chk("reset_gnt_id", 32'(gnt_id), 32'd0);

        rst_n = 1'b1;
        step();
        chk_state("first_grant", 1'b1, 1'b1, 4'b0001, 1'b0);
        req = 4'b0000;
        step();
        chk_state("first_tail1", 1'b0, 1'b1, 4'b0000, 1'b0);
        step();
        chk_state("first_tail2", 1'b0, 1'b1, 4'b0000, 1'b0);
        step();
        chk_state("first_idle", 1'b0, 1'b0, 4'b0000, 1'b0);

        // single 5-cycle burst from requester 2 (ptr=1)
        req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_state("single_read", 1'b1, 1'b1, 4'b0100, 1'b0);
        end
        req = 4'b0000;
        step();
        chk_state("single_tail1", 1'b0, 1'b1, 4'b0000, 1'b0);
        step();
        chk_state("single_tail2", 1'b0, 1'b1, 4'b0000, 1'b0);
        step();
        chk_state("single_idle", 1'b0, 1'b0, 4'b0000, 1'b0);
        chk("single_gnt_id", 32'(gnt_id), 32'd2);

        // minimum burst: requester 3 pulsed one cycle
        req = 4'b1000;
        step();
        chk_state("min_read", 1'b1, 1'b1, 4'b1000, 1'b0);
        req = 4'b0000;
        step();
        chk_state("min_tail1", 1'b0, 1'b1, 4'b0000, 1'b0);
        step();
        chk_state("min_tail2", 1'b0, 1'b1, 4'b0000, 1'b0);
        step();
        chk_state("min_idle", 1'b0, 1'b0, 4'b0000, 1'b0);

        // round-robin with all requesting; granted requester drops for one cycle
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_state("rr_grant", 1'b1, 1'b1, 4'b0001 << order[i], 1'b0);
            chk("rr_gnt_id", 32'(gnt_id), 32'(order[i]));
            req = 4'b1111 & ~(4'b0001 << order[i]);
            step();
            chk_state("rr_tail1", 1'b0, 1'b1, 4'b0000, 1'b0);
            req = (i == 7) ? 4'b0000 : 4'b1111;
            step();
            chk_state("rr_tail2", 1'b0, 1'b1, 4'b0000, 1'b0);
`ifndef READ_BUSY_CTRL_B2B_EN
            step();
            chk_state("rr_gap", 1'b0, 1'b0, 4'b0000, 1'b0);
`endif
        end
        step();
        chk_state("rr_drain", 1'b0, 1'b0, 4'b0000, 1'b0);

        // truncation at MAX_BURST=8 with requester 1 waiting
        req = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_state("trunc_read", 1'b1, 1'b1, 4'b0001, 1'b0);
        end
        step();
        chk_state("trunc_tail1", 1'b0, 1'b1, 4'b0000, 1'b1);
        step();
        chk_state("trunc_tail2", 1'b0, 1'b1, 4'b0000, 1'b0);
`ifndef READ_BUSY_CTRL_B2B_EN
        step();
        chk_state("trunc_gap", 1'b0, 1'b0, 4'b0000, 1'b0);
`endif
        step();
        chk_state("trunc_next", 1'b1, 1'b1, 4'b0010, 1'b0);
        chk("trunc_next_id", 32'(gnt_id), 32'd1);
        req = 4'b0000;
        step();
        step();
        step();
        chk_state("trunc_idle", 1'b0, 1'b0, 4'b0000, 1'b0);

        // reset on the third read cycle of a burst from requester 0
        req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state("rst_mid_read", 1'b1, 1'b1, 4'b0001, 1'b0);
        end
        rst_n = 1'b0;
        step();
        chk_state("rst_mid", 1'b0, 1'b0, 4'b0000, 1'b0);
        chk("rst_mid_gnt_id", 32'(gnt_id), 32'd0);
        rst_n = 1'b1;
        req   = 4'b1111;
        step();
        chk_state("rst_ptr_zero", 1'b1, 1'b1, 4'b0001, 1'b0);
        req = 4'b0000;
        step();
        step();
        step();
        chk_state("final_idle", 1'b0, 1'b0, 4'b0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
